mmm_nlp_256b_3way_mul: RTL and testbench

// - Fully pipelined 256x256-bit unsigned multiplier.
// - Uses a 3-way Karatsuba split into 87-bit limbs.
// - Integer product core of the modular-multiplication (MMM) datapath.
// - Accepts one new operand pair every clock.
// - Returns the full product a*b, zero-extended to ODW bits, exactly 4 clocks later.

---
 rtl/mmm_nlp_256b_3way_mul.sv | 165 ++++++++++++++++
 tb/tb_mmm_nlp_256b_3way_mul.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mmm_nlp_256b_3way_mul.sv
`default_nettype none
// ============================================================================
// Module   : mmm_nlp_256b_3way_mul
// Purpose  : Fully pipelined 256x256-bit unsigned multiplier using a 3-way
//            Karatsuba split into DIVW-bit limbs. This is the integer product
//            core of the modular-multiplication datapath. It accepts one
//            operand pair per clock and presents the full product 4 clocks
//            later.
// Ports    : i_clk  - rising-edge clock
//            i_rstn - asynchronous active-low reset, clears every stage
//            i_a    - IDW-bit unsigned multiplicand, sampled every edge
//            i_b    - IDW-bit unsigned multiplier, sampled every edge
//            o_res  - ODW-bit registered product a*b, zero-extended
// Revision : 1.0 - initial release
// ============================================================================
module mmm_nlp_256b_3way_mul #(
  parameter int IDW  = 256,
  parameter int DIVW = 87,
  parameter int ODW  = 522
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic [IDW-1:0] i_a,
  input  logic [IDW-1:0] i_b,
  output logic [ODW-1:0] o_res
);

  localparam int c_XW = 3 * DIVW;     // zero-extended operand width
  localparam int c_SW = DIVW + 1;     // limb pre-sum width
  localparam int c_PW = 2 * DIVW;     // plain limb product width
  localparam int c_QW = 2 * DIVW + 2; // pre-sum product / middle term width

  // --------------------------------------------------------------------------
  // Stage 1: limb split and pre-sums
  // --------------------------------------------------------------------------
  logic [c_XW-1:0] a_ext_d, b_ext_d;
  logic [DIVW-1:0] a0_d, a1_d, a2_d, b0_d, b1_d, b2_d;
  logic [c_SW-1:0] sa01_d, sa02_d, sa12_d, sb01_d, sb02_d, sb12_d;

  logic [DIVW-1:0] a0_q, a1_q, a2_q, b0_q, b1_q, b2_q;
  logic [c_SW-1:0] sa01_q, sa02_q, sa12_q, sb01_q, sb02_q, sb12_q;

  // --------------------------------------------------------------------------
  // Stage 2: six limb products
  // --------------------------------------------------------------------------
  logic [c_PW-1:0] p0_d, p1_d, p2_d;
  logic [c_QW-1:0] p01_d, p02_d, p12_d;

  logic [c_PW-1:0] p0_q, p1_q, p2_q;
  logic [c_QW-1:0] p01_q, p02_q, p12_q;

  // --------------------------------------------------------------------------
  // Stage 3: middle terms, P0/P2 carried alongside
  // --------------------------------------------------------------------------
  logic [c_QW-1:0] m1_d, m2_d, m3_d;

  logic [c_PW-1:0] p0_s3_q, p2_s3_q;
  logic [c_QW-1:0] m1_q, m2_q, m3_q;

  // --------------------------------------------------------------------------
  // Stage 4: final recombination
  // --------------------------------------------------------------------------
  logic [ODW-1:0] res_d;
  logic [ODW-1:0] res_q;

  always_comb begin
    // Operands are zero-extended so the top limb carries the short remainder.
    a_ext_d = c_XW'(i_a);
    b_ext_d = c_XW'(i_b);

    a0_d = a_ext_d[DIVW-1:0];
    a1_d = a_ext_d[2*DIVW-1:DIVW];
    a2_d = a_ext_d[3*DIVW-1:2*DIVW];
    b0_d = b_ext_d[DIVW-1:0];
    b1_d = b_ext_d[2*DIVW-1:DIVW];
    b2_d = b_ext_d[3*DIVW-1:2*DIVW];

    sa01_d = c_SW'(a0_d) + c_SW'(a1_d);
    sa02_d = c_SW'(a0_d) + c_SW'(a2_d);
    sa12_d = c_SW'(a1_d) + c_SW'(a2_d);
    sb01_d = c_SW'(b0_d) + c_SW'(b1_d);
    sb02_d = c_SW'(b0_d) + c_SW'(b2_d);
    sb12_d = c_SW'(b1_d) + c_SW'(b2_d);

    p0_d  = c_PW'(a0_q) * c_PW'(b0_q);
    p1_d  = c_PW'(a1_q) * c_PW'(b1_q);
    p2_d  = c_PW'(a2_q) * c_PW'(b2_q);
    p01_d = c_QW'(sa01_q) * c_QW'(sb01_q);
    p02_d = c_QW'(sa02_q) * c_QW'(sb02_q);
    p12_d = c_QW'(sa12_q) * c_QW'(sb12_q);

    // Subtraction order keeps every partial result non-negative:
    //   P01 - P0 - P1         = a0b1 + a1b0
    //   P02 - P0 - P2 (+ P1)  = a0b2 + a2b0 (+ a1b1)  < 3*2^(2D)
    //   P12 - P1 - P2         = a1b2 + a2b1
    // so c_QW bits hold each step without wrapping.
    m1_d = p01_q - c_QW'(p0_q) - c_QW'(p1_q);
    m2_d = p02_q - c_QW'(p0_q) - c_QW'(p2_q) + c_QW'(p1_q);
    m3_d = p12_q - c_QW'(p1_q) - c_QW'(p2_q);

    res_d = ODW'(p0_s3_q)
          + (ODW'(m1_q)    << DIVW)
          + (ODW'(m2_q)    << (2 * DIVW))
          + (ODW'(m3_q)    << (3 * DIVW))
          + (ODW'(p2_s3_q) << (4 * DIVW));
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      a0_q    <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      sa01_q  <= '0;
      sa02_q  <= '0;
      sa12_q  <= '0;
      sb01_q  <= '0;
      sb02_q  <= '0;
      sb12_q  <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      p01_q   <= '0;
      p02_q   <= '0;
      p12_q   <= '0;
      p0_s3_q <= '0;
      p2_s3_q <= '0;
      m1_q    <= '0;
      m2_q    <= '0;
      m3_q    <= '0;
      res_q   <= '0;
    end else begin
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      sa01_q  <= sa01_d;
      sa02_q  <= sa02_d;
      sa12_q  <= sa12_d;
      sb01_q  <= sb01_d;
      sb02_q  <= sb02_d;
      sb12_q  <= sb12_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      p01_q   <= p01_d;
      p02_q   <= p02_d;
      p12_q   <= p12_d;
      p0_s3_q <= p0_q;
      p2_s3_q <= p2_q;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      m3_q    <= m3_d;
      res_q   <= res_d;
    end
  end

  assign o_res = res_q;

endmodule
`default_nettype wire

// File: tb/tb_mmm_nlp_256b_3way_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmm_nlp_256b_3way_mul
// Purpose  : Self-checking bench for mmm_nlp_256b_3way_mul. Directed vectors
//            from a table, a long random stream and reset sequences; every
//            expected product is queued when its operands are driven and
//            popped when the pipeline should deliver it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmm_nlp_256b_3way_mul;

  localparam int c_IDW = 256;
  localparam int c_ODW = 522;
  localparam int c_LAT = 4;

  logic             i_clk;
  logic             i_rstn;
  logic [c_IDW-1:0] i_a;
  logic [c_IDW-1:0] i_b;
  logic [c_ODW-1:0] o_res;

  int total = 0;
  int bad   = 0;

  logic [c_ODW-1:0] exp_q[$];

  typedef struct {
    logic [255:0] a;
    logic [255:0] b;
    logic [511:0] e;
    string        nm;
  } vec_t;

  vec_t vec[8];

  mmm_nlp_256b_3way_mul #(
    .IDW (256),
    .DIVW(87),
    .ODW (522)
  ) u_dut (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .i_a   (i_a),
    .i_b   (i_b),
    .o_res (o_res)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string nm, input logic [c_ODW-1:0] act,
                       input logic [c_ODW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // One clock of stimulus. With rst_lo the reset is pulled low at the
  // negedge (asynchronously) and the scoreboard is flushed.
  task automatic cyc(input logic [255:0] a, input logic [255:0] b,
                     input bit rst_lo, input string nm);
    logic [511:0] full;
    @(negedge i_clk);
    i_a = a;
    i_b = b;
    if (rst_lo) begin
      i_rstn = 1'b0;
      #1;
      check({nm, "_async_clear"}, o_res, '0);
      exp_q.delete();
    end else begin
      i_rstn = 1'b1;
    end
    @(posedge i_clk);
    #1;
    if (rst_lo) begin
      check({nm, "_hold"}, o_res, '0);
    end else begin
      full = 512'(a) * 512'(b);
      exp_q.push_back(c_ODW'(full));
      if (exp_q.size() >= c_LAT) check(nm, o_res, exp_q.pop_front());
      else                       check({nm, "_fill"}, o_res, '0);
    end
  endtask

  // Directed vector with a hand-derived expectation; the queue carries the
  // table value instead of a*b.
  task automatic cyc_vec(input vec_t v);
    @(negedge i_clk);
    i_a    = v.a;
    i_b    = v.b;
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;
    exp_q.push_back(c_ODW'(v.e));
    if (exp_q.size() >= c_LAT) check(v.nm, o_res, exp_q.pop_front());
    else                       check({v.nm, "_fill"}, o_res, '0);
  endtask

  initial begin
    logic [255:0] x;
    logic [511:0] ones512;
    logic [511:0] one512;

    i_rstn  = 1'b0;
    i_a     = rnd256();
    i_b     = rnd256();
    x       = rnd256();
    one512  = 512'd1;
    ones512 = '1;

    vec[0].a = '0;                 vec[0].b = rnd256();
    vec[0].e = '0;                 vec[0].nm = "zero";
    vec[1].a = 256'd1;             vec[1].b = x;
    vec[1].e = 512'(x);            vec[1].nm = "identity";
    vec[2].a = '1;                 vec[2].b = '1;
    vec[2].e = ones512 - (one512 << 257) + 512'd2;
    vec[2].nm = "max";
    vec[3].a = (256'd1 << 87) - 256'd1;
    vec[3].b = (256'd1 << 87) - 256'd1;
    vec[3].e = (one512 << 174) - (one512 << 88) + 512'd1;
    vec[3].nm = "limb0_ones";
    vec[4].a = 256'd1 << 174;     vec[4].b = 256'd1 << 174;
    vec[4].e = one512 << 348;      vec[4].nm = "pow174";
    vec[5].a = 256'd1 << 87;      vec[5].b = 256'd1 << 87;
    vec[5].e = one512 << 174;      vec[5].nm = "pow87";
    vec[6].a = '1;                 vec[6].b = 256'd1;
    vec[6].e = 512'({256{1'b1}});  vec[6].nm = "max_x_one";
    vec[7].a = 256'd1 << 255;     vec[7].b = 256'd1 << 86;
    vec[7].e = one512 << 341;      vec[7].nm = "cross_hi_lo";

    // Reset held with random inputs: output must stay zero.
    for (int i = 0; i < 5; i++) cyc(rnd256(), rnd256(), 1'b1, "rst_init");

    // Directed table straight after release (first three outputs are fill).
    for (int i = 0; i < 8; i++) cyc_vec(vec[i]);

    // Back-to-back random stream.
    for (int i = 0; i < 120; i++) cyc(rnd256(), rnd256(), 1'b0, "stream");

    // Three more ops in flight, then a one-cycle reset mid-stream.
    for (int i = 0; i < 3; i++) cyc(rnd256(), rnd256(), 1'b0, "pre_rst");
    cyc(rnd256(), rnd256(), 1'b1, "mid_rst");

    // Resume: three zero outputs, then correct results again.
    for (int i = 0; i < 12; i++) cyc(rnd256(), rnd256(), 1'b0, "resume");

    // Drain.
    for (int i = 0; i < c_LAT; i++) cyc('0, '0, 1'b0, "drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
